// File: rtl/ex_mem_pipe_stage_if.sv
// EX/MEM pipeline bus: EX-side entry + handshake in, MEM-side entry + handshake out.
// master drives the EX side and consumes the MEM side; slave is the stage itself.
interface ex_mem_pipe_stage_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) ();
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic              branch;
    logic              mem_read;
    logic              memto_reg;
    logic              mem_write;
    logic              reg_write;
    logic              zero;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] aluresult;
    logic [DATA_W-1:0] read_out2;
    logic [DATA_W-1:0] incinst;

    logic              out_valid;
    logic              out_ready;
    logic              branch_out;
    logic              mem_read_out;
    logic              memto_reg_out;
    logic              mem_write_out;
    logic              reg_write_out;
    logic              zero_out;
    logic [ADDR_W-1:0] write_address_out;
    logic [DATA_W-1:0] aluresult_out;
    logic [DATA_W-1:0] read_out2_out;
    logic [DATA_W-1:0] incinst_out;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, flush, out_ready,
        output branch, mem_read, memto_reg, mem_write, reg_write, zero,
        output write_address, aluresult, read_out2, incinst,
        input  in_ready, out_valid, stall_cnt,
        input  branch_out, mem_read_out, memto_reg_out,
        input  mem_write_out, reg_write_out, zero_out,
        input  write_address_out, aluresult_out, read_out2_out, incinst_out
    );

    modport slave (
        input  in_valid, flush, out_ready,
        input  branch, mem_read, memto_reg, mem_write, reg_write, zero,
        input  write_address, aluresult, read_out2, incinst,
        output in_ready, out_valid, stall_cnt,
        output branch_out, mem_read_out, memto_reg_out,
        output mem_write_out, reg_write_out, zero_out,
        output write_address_out, aluresult_out, read_out2_out, incinst_out
    );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// EX/MEM pipeline stage with valid/ready handshake, flush, bubble gating, stall counter.
// EXMEM_SKID_EN selects the two-entry skid build with a registered in_ready.
module ex_mem_pipe_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input logic                clk,
    input logic                rst,
    ex_mem_pipe_stage_if.slave bus
);

    typedef struct packed {
        logic              branch;
        logic              mem_read;
        logic              memto_reg;
        logic              mem_write;
        logic              reg_write;
        logic              zero;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] alu;
        logic [DATA_W-1:0] ro2;
        logic [DATA_W-1:0] inc;
    } entry_t;

    entry_t           in_e;
    entry_t           main_q;
    logic             in_ready;
    logic             out_valid;
    logic             acc;
    logic             fire;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    assign in_e = {bus.branch, bus.mem_read, bus.memto_reg,
                   bus.mem_write, bus.reg_write, bus.zero,
                   bus.write_address, bus.aluresult,
                   bus.read_out2, bus.incinst};

    assign acc  = bus.in_valid & in_ready;
    assign fire = out_valid & bus.out_ready;

`ifdef EXMEM_SKID_EN
    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_e;

    state_e state_q;
    entry_t skid_q;
    logic   rdy_q;

    // rdy_q tracks "next state != FULL" so in_ready never sees out_ready
    assign in_ready  = rdy_q & ~rst;
    assign out_valid = (state_q != EMPTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
        end else if (bus.flush) begin
            state_q <= EMPTY;
            rdy_q   <= 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (acc) begin
                        main_q  <= in_e;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    if (acc && fire) begin
                        main_q <= in_e;
                    end else if (acc) begin
                        skid_q  <= in_e;
                        state_q <= FULL;
                        rdy_q   <= 1'b0;
                    end else if (fire) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (fire) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                        rdy_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    rdy_q   <= 1'b1;
                end
            endcase
        end
    end
`else
    typedef enum logic {
        EMPTY,
        ONE
    } state_e;

    state_e state_q;

    assign in_ready  = ~rst & (~out_valid | bus.out_ready);
    assign out_valid = (state_q == ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
        end else if (bus.flush) begin
            state_q <= EMPTY;
        end else if (acc) begin
            main_q  <= in_e;
            state_q <= ONE;
        end else if (fire) begin
            state_q <= EMPTY;
        end
    end
`endif

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !bus.out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.stall_cnt = stall_cnt_q;

    // side-effecting controls are masked on bubbles; payload keeps last value
    assign bus.branch_out        = main_q.branch & out_valid;
    assign bus.mem_read_out      = main_q.mem_read & out_valid;
    assign bus.mem_write_out     = main_q.mem_write & out_valid;
    assign bus.reg_write_out     = main_q.reg_write & out_valid;
    assign bus.memto_reg_out     = main_q.memto_reg;
    assign bus.zero_out          = main_q.zero;
    assign bus.write_address_out = main_q.waddr;
    assign bus.aluresult_out     = main_q.alu;
    assign bus.read_out2_out     = main_q.ro2;
    assign bus.incinst_out       = main_q.inc;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed bench for ex_mem_pipe_stage; expectations follow the EXMEM_SKID_EN setting.
// A second instance with CNT_W=4 covers stall counter saturation.
module tb_ex_mem_pipe_stage;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ex_mem_pipe_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();
    ex_mem_pipe_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

    ex_mem_pipe_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ex_mem_pipe_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic rw);
        bus.in_valid      = v;
        bus.aluresult     = a;
        bus.read_out2     = ~a;
        bus.incinst       = a + 32'd4;
        bus.write_address = a[4:0];
        bus.reg_write     = rw;
        bus.mem_write     = rw;
        bus.branch        = 1'b1;
        bus.mem_read      = 1'b1;
        bus.memto_reg     = 1'b1;
        bus.zero          = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h55, 1'b1);
        bus4.in_valid      = 1'b0;
        bus4.flush         = 1'b0;
        bus4.out_ready     = 1'b1;
        bus4.branch        = 1'b0;
        bus4.mem_read      = 1'b0;
        bus4.memto_reg     = 1'b0;
        bus4.mem_write     = 1'b0;
        bus4.reg_write     = 1'b0;
        bus4.zero          = 1'b0;
        bus4.write_address = 5'd0;
        bus4.aluresult     = 32'd0;
        bus4.read_out2     = 32'd0;
        bus4.incinst       = 32'd0;

        // reset held 3 cycles with traffic presented
        tick();
        tick();
        tick();
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_alu", bus.aluresult_out, 0);
        chk("rst_memto", bus.memto_reg_out, 0);
        chk("rst_zero", bus.zero_out, 0);
        chk("rst_waddr", bus.write_address_out, 0);
        chk("rst_regwr", bus.reg_write_out, 0);
        chk("rst_stall", bus.stall_cnt, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst4_stall", bus4.stall_cnt, 0);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        #1;
        chk("post_rst_in_ready", bus.in_ready, 1);
        chk("post_rst4_in_ready", bus4.in_ready, 1);

        // streaming 1..8 with out_ready=1
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 1'b1);
            tick();
            chk($sformatf("stream_valid_%0d", i), bus.out_valid, 1);
            chk($sformatf("stream_alu_%0d", i), bus.aluresult_out, 64'(i));
            if (i == 5) begin
                chk("stream_ro2", bus.read_out2_out, 64'hFFFF_FFFA);
                chk("stream_inc", bus.incinst_out, 64'd9);
                chk("stream_waddr", bus.write_address_out, 64'd5);
                chk("stream_regwr", bus.reg_write_out, 1);
            end
        end
        drive(1'b0, 32'h0, 1'b0);
        tick();
        chk("drain_valid", bus.out_valid, 0);
        chk("drain_branch_gated", bus.branch_out, 0);
        chk("drain_memwr_gated", bus.mem_write_out, 0);
        chk("drain_alu_hold", bus.aluresult_out, 64'd8);
        chk("drain_memto_hold", bus.memto_reg_out, 1);

`ifdef EXMEM_SKID_EN
        // backpressure fills main+skid, third entry held upstream
        drive(1'b1, 32'hA, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hB, 1'b0);
        tick();
        chk("bp_full_in_ready", bus.in_ready, 0);
        drive(1'b1, 32'hC, 1'b0);
        tick();
        tick();
        tick();
        chk("bp_stall", bus.stall_cnt, 64'd4);
        chk("bp_main", bus.aluresult_out, 64'hA);
        chk("bp_in_ready", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        tick();
        chk("rel_1", bus.aluresult_out, 64'hB);
        chk("rel_1_valid", bus.out_valid, 1);
        tick();
        chk("rel_2", bus.aluresult_out, 64'hC);
        drive(1'b0, 32'h0, 1'b0);
        tick();
        chk("rel_empty", bus.out_valid, 0);
        chk("rel_stall", bus.stall_cnt, 64'd4);

        // flush while FULL, with an input entry presented
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hD, 1'b1);
        tick();
        drive(1'b1, 32'hE, 1'b1);
        tick();
        chk("fl_full_in_ready", bus.in_ready, 0);
        bus.flush = 1'b1;
        drive(1'b1, 32'hF, 1'b1);
        tick();
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_regwr", bus.reg_write_out, 0);
        chk("fl_memwr", bus.mem_write_out, 0);
        chk("fl_in_ready", bus.in_ready, 1);
        chk("fl_alu_hold", bus.aluresult_out, 64'hD);
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        tick();
        chk("fl_dropped", bus.out_valid, 0);
        chk("fl_stall", bus.stall_cnt, 64'd6);
`else
        // backpressure: in_ready follows out_ready combinationally
        drive(1'b1, 32'hA, 1'b0);
        tick();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hB, 1'b0);
        #1;
        chk("bp_in_ready_low", bus.in_ready, 0);
        tick();
        tick();
        tick();
        chk("bp_stall", bus.stall_cnt, 64'd3);
        chk("bp_main", bus.aluresult_out, 64'hA);
        bus.out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", bus.in_ready, 1);
        tick();
        chk("rel_replace", bus.aluresult_out, 64'hB);
        chk("rel_valid", bus.out_valid, 1);
        drive(1'b0, 32'h0, 1'b0);
        tick();
        chk("rel_empty", bus.out_valid, 0);

        // flush beats accept in the same cycle
        bus.out_ready = 1'b0;
        drive(1'b1, 32'hD, 1'b1);
        tick();
        bus.out_ready = 1'b1;
        bus.flush     = 1'b1;
        drive(1'b1, 32'hF, 1'b1);
        tick();
        chk("fl_valid", bus.out_valid, 0);
        chk("fl_regwr", bus.reg_write_out, 0);
        chk("fl_memwr", bus.mem_write_out, 0);
        chk("fl_in_ready", bus.in_ready, 1);
        chk("fl_alu_hold", bus.aluresult_out, 64'hD);
        bus.flush = 1'b0;
        drive(1'b0, 32'h0, 1'b0);
        tick();
        chk("fl_dropped", bus.out_valid, 0);
        chk("fl_stall", bus.stall_cnt, 64'd3);
`endif

        // reset mid-operation discards the held entry
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h99, 1'b1);
        tick();
        chk("mid_valid", bus.out_valid, 1);
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_alu", bus.aluresult_out, 0);
        chk("mid_rst_stall", bus.stall_cnt, 0);
        chk("mid_rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 32'h0, 1'b0);

        // stall counter saturation on the CNT_W=4 instance
        bus4.in_valid  = 1'b1;
        bus4.aluresult = 32'h77;
        bus4.out_ready = 1'b0;
        tick();
        bus4.in_valid = 1'b0;
        for (int k = 0; k < 14; k++) tick();
        chk("sat_mid", bus4.stall_cnt, 64'd14);
        for (int k = 0; k < 6; k++) tick();
        chk("sat_top", bus4.stall_cnt, 64'd15);
        chk("sat_alu", bus4.aluresult_out, 64'h77);
        bus4.flush = 1'b1;
        tick();
        bus4.flush = 1'b0;
        chk("sat_flush_valid", bus4.out_valid, 0);
        chk("sat_flush_keep", bus4.stall_cnt, 64'd15);
        tick();
        chk("sat_hold", bus4.stall_cnt, 64'd15);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
